// File: rtl/strip_result_drain.sv
// strip_result_drain: streams every result of the strip-2 conv unit out of its result BRAM
// once the unit reports done. Reads are credit-limited so the skid FIFO can never overflow,
// the BRAM read latency is tracked by a valid shift register, and each 23-bit signed sum is
// shifted and saturated to OUT_W bits before it enters the FIFO.
// Optional feature: define DRAIN_RELU_EN to clamp negative sums to zero before rescaling.
module strip_result_drain #(
  parameter int NUM_RESULTS = 6216,
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 23,
  parameter int OUT_W       = 8,
  parameter int SHIFT       = 0,
  parameter int RD_LAT      = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              conv_done,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_last,
  output logic              busy,
  output logic              drain_done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W-1:0]        LAST_IDX = ADDR_W'(NUM_RESULTS - 1);
  localparam logic signed [DATA_W-1:0] SAT_MAX  = DATA_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [DATA_W-1:0] SAT_MIN  = DATA_W'(-(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FLUSH,
    S_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic                armed_q, armed_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [RD_LAT-1:0]   sr_vld_q;
  logic [RD_LAT-1:0]   sr_last_q;
  logic [OUT_W:0]      fifo_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       inflight;
  logic                can_issue, push, pop;
  logic signed [DATA_W-1:0] din_s, shifted;
  logic [OUT_W-1:0]    sat_data;

  // Count reads still travelling through the BRAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(sr_vld_q[i]);
  end

  // Credit rule: a read may issue only if its result is guaranteed a FIFO slot.
  always_comb begin
    can_issue = (state_q == S_ISSUE) && ((count_q + inflight) < CW'(FIFO_DEPTH));
    push      = sr_vld_q[RD_LAT-1];
    pop       = m_valid && m_ready;
  end

  // Rescale: optional ReLU, arithmetic shift, then saturate to the OUT_W signed range.
  always_comb begin
    din_s = $signed(bram_dout);
`ifdef DRAIN_RELU_EN
    if (din_s[DATA_W-1]) din_s = '0;
`else
`endif
    shifted = din_s >>> SHIFT;
    if (shifted > SAT_MAX)      sat_data = SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN) sat_data = SAT_MIN[OUT_W-1:0];
    else                        sat_data = shifted[OUT_W-1:0];
  end

  // Next-state and address logic for the drain FSM.
  // NOTE: every signal gets a default at the top so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    addr_d  = addr_q;
    if (!conv_done) armed_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (conv_done && armed_q) begin
          state_d = S_ISSUE;
          armed_d = 1'b0;
          addr_d  = '0;
        end
      end
      S_ISSUE: begin
        if (can_issue) begin
          if (addr_q == LAST_IDX) state_d = S_FLUSH;
          else                    addr_d  = addr_q + 1'b1;
        end
      end
      S_FLUSH: begin
        // Leave as soon as the final beat is being accepted so done follows it by one cycle.
        if ((inflight == '0) && ((count_q == '0) || ((count_q == CW'(1)) && pop)))
          state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM, address and read-tracking registers; reset discards any reads in flight.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b1;
      addr_q    <= '0;
      sr_vld_q  <= '0;
      sr_last_q <= '0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      addr_q       <= addr_d;
      sr_vld_q[0]  <= can_issue;
      sr_last_q[0] <= can_issue && (addr_q == LAST_IDX);
      for (int i = 1; i < RD_LAT; i++) begin
        sr_vld_q[i]  <= sr_vld_q[i-1];
        sr_last_q[i] <= sr_last_q[i-1];
      end
    end
  end

  // FIFO pointers and occupancy; push and pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage: rescaled result with its last-beat tag.
  // NOTE: storage is not reset; the occupancy count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {sr_last_q[RD_LAT-1], sat_data};
  end

  assign bram_addr  = addr_q;
  assign m_valid    = (count_q != '0);
  assign m_data     = m_valid ? fifo_q[rd_ptr_q][OUT_W-1:0] : '0;
  assign m_last     = m_valid ? fifo_q[rd_ptr_q][OUT_W] : 1'b0;
  assign busy       = (state_q == S_ISSUE) || (state_q == S_FLUSH);
  assign drain_done = (state_q == S_FINISH);

endmodule

// File: tb/tb_strip_result_drain.sv
// Scoreboard bench for strip_result_drain: stimulus pushes expected beats into a queue,
// monitors pop and compare on every accepted beat. A second instance covers NUM_RESULTS=1.
module tb_strip_result_drain;

  localparam int N  = 6216;
  localparam int AW = 13;
  localparam int DW = 23;
  localparam int OW = 8;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n, conv_done, m_ready;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout;
  logic m_valid, m_last, busy, drain_done;
  logic [OW-1:0] m_data;

  logic conv_done_s, m_ready_s;
  logic [AW-1:0] bram_addr_s;
  logic [DW-1:0] bram_dout_s;
  logic m_valid_s, m_last_s, busy_s, drain_done_s;
  logic [OW-1:0] m_data_s;

  logic signed [DW-1:0] mem [N];
  logic [DW-1:0] p1 = '0, p2 = '0, q1 = '0, q2 = '0;

  beat_t exp_q[$];
  beat_t exp_s_q[$];
  int checks = 0, errors = 0;
  int beats = 0, dones = 0, dones_s = 0;
  int rdy_mode = 0;
  longint last_acc_t = 0;

  always #5 clk = ~clk;

  strip_result_drain u_dut (
    .clk(clk), .reset_n(reset_n), .conv_done(conv_done), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .drain_done(drain_done)
  );

  strip_result_drain #(.NUM_RESULTS(1), .SHIFT(2)) u_small (
    .clk(clk), .reset_n(reset_n), .conv_done(conv_done_s), .bram_addr(bram_addr_s),
    .bram_dout(bram_dout_s), .m_valid(m_valid_s), .m_ready(m_ready_s), .m_data(m_data_s),
    .m_last(m_last_s), .busy(busy_s), .drain_done(drain_done_s)
  );

  // Two-cycle BRAM models (address register + output register).
  always @(posedge clk) begin
    p1 <= mem[bram_addr];
    p2 <= p1;
    q1 <= (bram_addr_s == '0) ? DW'(-9) : '0;
    q2 <= q1;
  end
  assign bram_dout   = p2;
  assign bram_dout_s = q2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] exp_of(input int v);
    int s;
    s = v;
`ifdef DRAIN_RELU_EN
    if (s < 0) s = 0;
`endif
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return OW'(s);
  endfunction

  // Queue the expected stream for one full drain of the main instance.
  task automatic push_drain(input bit specials);
    beat_t e;
    for (int i = 0; i < N; i++) begin
      e.data = exp_of(int'(mem[i]));
      if (specials && i < 3) begin
`ifdef DRAIN_RELU_EN
        e.data = (i == 1) ? 8'sd127 : 8'sd0;
`else
        e.data = (i == 0) ? 8'h80 : (i == 1) ? 8'h7f : 8'hfb;
`endif
      end
      e.last = (i == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    bit seen;
    d0 = dones;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (dones > d0) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Backpressure driver: always ready, 1-on/1-off toggling, or random stalls.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((($time / 10000) % 2) == 0) ? ~m_ready : ($urandom_range(0, 3) != 0);
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Main monitor: scoreboard compare, stall stability, drain_done timing.
  initial begin
    bit hold_v, done_exp;
    logic [OW-1:0] hold_d;
    logic hold_l;
    beat_t e;
    hold_v = 0; done_exp = 0; hold_d = '0; hold_l = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_v = 0;
        done_exp = 0;
      end else begin
        if (done_exp) begin
          check("drain_done_pulse", 32'(drain_done), 32'd1);
          check("busy_low_at_done", 32'(busy), 32'd0);
          done_exp = 0;
          dones++;
        end else if (drain_done) begin
          check("unexpected_drain_done", 32'(drain_done), 32'd0);
        end
        if (hold_v) begin
          check("stall_valid", 32'(m_valid), 32'd1);
          check("stall_data", 32'(m_data), 32'(hold_d));
          check("stall_last", 32'(m_last), 32'(hold_l));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(m_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 32'(m_data), 32'(e.data));
            check("beat_last", 32'(m_last), 32'(e.last));
            if (e.last) done_exp = 1;
          end
          beats++;
          last_acc_t = $time;
        end
        hold_v = m_valid && !m_ready;
        hold_d = m_data;
        hold_l = m_last;
      end
    end
  end

  // Small-instance monitor (NUM_RESULTS=1).
  initial begin
    bit done_exp;
    beat_t e;
    done_exp = 0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (done_exp) begin
          check("small_drain_done", 32'(drain_done_s), 32'd1);
          check("small_busy_at_done", 32'(busy_s), 32'd0);
          done_exp = 0;
          dones_s++;
        end else if (drain_done_s) begin
          check("small_unexpected_done", 32'(drain_done_s), 32'd0);
        end
        if (m_valid_s && m_ready_s) begin
          if (exp_s_q.size() == 0) begin
            check("small_unexpected_beat", 32'(m_valid_s), 32'd0);
          end else begin
            e = exp_s_q.pop_front();
            check("small_data", 32'(m_data_s), 32'(e.data));
            check("small_last", 32'(m_last_s), 32'(e.last));
            if (e.last) done_exp = 1;
          end
        end
      end
    end
  end

  initial begin
    int lat, b0;
    longint first_t;
    bit ok;
    beat_t e;
    reset_n = 1'b0; conv_done = 1'b0; conv_done_s = 1'b0; m_ready_s = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = DW'(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", 32'(bram_addr), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(drain_done), 32'd0);
    reset_n = 1'b1;

    // Back-to-back drain of BRAM[i]=i with ready held high.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    push_drain(1'b0);
    conv_done = 1'b1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = busy;
    end
    check("busy_rise", 32'(ok), 32'd1);
    lat = 0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      lat++;
      ok = m_valid;
    end
    check("first_valid_latency", 32'(lat), 32'd3);
    first_t = $time;
    wait_done(N + 50, "t1");
    check("back_to_back_span", 32'((last_acc_t - first_t) / 10), 32'(N - 1));

    // conv_done still high: no second drain.
    repeat (40) @(negedge clk);
    check("no_redrain_busy", 32'(busy), 32'd0);
    check("no_redrain_valid", 32'(m_valid), 32'd0);

    // Saturation vectors under toggling / random backpressure, re-armed by a low pulse.
    mem[0] = DW'(-300); mem[1] = DW'(300); mem[2] = DW'(-5);
    @(posedge clk);
    #1;
    conv_done = 1'b0;
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    push_drain(1'b1);
    conv_done = 1'b1;
    wait_done(5 * N, "t2");
    rdy_mode = 0;

    // Reset at beat 100, then fresh drain with conv_done held high.
    @(posedge clk);
    #1;
    conv_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_drain(1'b1);
    b0 = beats;
    conv_done = 1'b1;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = (beats - b0) >= 100;
    end
    check("reach_beat_100", 32'(ok), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_data", 32'(m_data), 32'd0);
    check("midrst_last", 32'(m_last), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_addr", 32'(bram_addr), 32'd0);
    check("midrst_done", 32'(drain_done), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    push_drain(1'b1);
    reset_n = 1'b1;
    wait_done(N + 50, "t4");
    conv_done = 1'b0;

    // Single-result instance: one beat with last, done follows, back to idle.
`ifdef DRAIN_RELU_EN
    e.data = 8'h00;
`else
    e.data = 8'hfd;
`endif
    e.last = 1'b1;
    exp_s_q.push_back(e);
    @(posedge clk);
    #1;
    conv_done_s = 1'b1;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = dones_s > 0;
    end
    check("small_done_seen", 32'(ok), 32'd1);
    check("small_queue_empty", 32'(exp_s_q.size()), 32'd0);
    @(negedge clk);
    check("small_idle_busy", 32'(busy_s), 32'd0);
    check("small_idle_valid", 32'(m_valid_s), 32'd0);
    conv_done_s = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
